uart_tx_fifo: RTL

- Byte buffer and dispatcher that sits directly upstream of the UART byte transmitter.
- Accepts bytes from logic (for example a command/response engine) in single-cycle writes and stores them in a circular FIFO.
- Feeds bytes one at a time to the transmitter through its send/data/busy handshake, so producers need not track transmitter timing.

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_tx_fifo_if.sv | 23 ++
 rtl/uart_fifo_mem.sv | 17 +
 rtl/uart_tx_fifo.sv | 81 ++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART byte width, dispatcher FSM encoding and baud divisors (50 MHz clock)
package uart_pkg;
  localparam int BYTE_W = 8;
  localparam int CLK_PER_BIT_9600 = 5208;
  localparam int CLK_PER_BIT_57600 = 868;
  localparam int CLK_PER_BIT_115200 = 434;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_DONE = 2'd2
  } tx_state_e;
endpackage

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: producer write port plus transmitter handshake; ovf/ovf_clr exist only with UART_TX_FIFO_OVF_EN
interface uart_tx_fifo_if import uart_pkg::*; #(
  parameter int DEPTH = 16,
  localparam int ADDR_BITS = $clog2(DEPTH)
) ();
  logic              wr_en;
  logic [BYTE_W-1:0] wr_data;
  logic              full;
  logic              empty;
  logic [ADDR_BITS:0] count;
  logic              tx_busy;
  logic              tx_send;
  logic [BYTE_W-1:0] tx_data;
`ifdef UART_TX_FIFO_OVF_EN
  logic              ovf;
  logic              ovf_clr;
  modport master (output wr_en, wr_data, tx_busy, ovf_clr, input full, empty, count, tx_send, tx_data, ovf);
  modport slave  (input wr_en, wr_data, tx_busy, ovf_clr, output full, empty, count, tx_send, tx_data, ovf);
`else
  modport master (output wr_en, wr_data, tx_busy, input full, empty, count, tx_send, tx_data);
  modport slave  (input wr_en, wr_data, tx_busy, output full, empty, count, tx_send, tx_data);
`endif
endinterface

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: DEPTH x byte storage with synchronous write and asynchronous read
module uart_fifo_mem import uart_pkg::*; #(
  parameter int DEPTH = 16,
  localparam int ADDR_BITS = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] waddr_i,
  input  logic [BYTE_W-1:0]    wdata_i,
  input  logic [ADDR_BITS-1:0] raddr_i,
  output logic [BYTE_W-1:0]    rdata_o
);
  logic [BYTE_W-1:0] mem_q [DEPTH];
  // storage is intentionally left unreset
  always_ff @(posedge clk) if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular byte FIFO that dispatches to a UART transmitter via send/busy; UART_TX_FIFO_OVF_EN adds a sticky overflow flag
module uart_tx_fifo import uart_pkg::*; #(
  parameter int DEPTH = 16,
  localparam int ADDR_BITS = $clog2(DEPTH)
) (
  input logic           clk,
  input logic           rst_n,
  uart_tx_fifo_if.slave bus
);
  localparam logic [ADDR_BITS:0] FULL_CNT = (ADDR_BITS + 1)'(DEPTH);
  tx_state_e state_q, state_d;
  logic [ADDR_BITS-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_BITS:0] count_q, count_d;
  logic full_q, empty_q, tx_send_q, tx_send_d, pop, accept;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d, rd_data;

  uart_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .we_i    (accept),
    .waddr_i (wr_ptr_q),
    .wdata_i (bus.wr_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  // dispatch decision, write acceptance and occupancy update
  always_comb begin
    state_d = state_q;
    pop = 1'b0;
    case (state_q)
      IDLE: begin
        pop = !empty_q && !bus.tx_busy;
        state_d = pop ? WAIT_ACK : IDLE;
      end
      WAIT_ACK:  state_d = bus.tx_busy ? WAIT_DONE : WAIT_ACK;
      WAIT_DONE: state_d = bus.tx_busy ? WAIT_DONE : IDLE;
      default:   state_d = IDLE;
    endcase
    accept = bus.wr_en && (count_q != FULL_CNT || pop);
    count_d = count_q + {{ADDR_BITS{1'b0}}, accept} - {{ADDR_BITS{1'b0}}, pop};
    tx_send_d = pop;
    tx_data_d = pop ? rd_data : tx_data_q;
  end

  // state, pointers, flags and transmitter outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      tx_send_q <= 1'b0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= accept ? wr_ptr_q + ADDR_BITS'(1) : wr_ptr_q;
      rd_ptr_q  <= pop ? rd_ptr_q + ADDR_BITS'(1) : rd_ptr_q;
      count_q   <= count_d;
      full_q    <= count_d == FULL_CNT;
      empty_q   <= count_d == '0;
      tx_send_q <= tx_send_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign bus.full    = full_q;
  assign bus.empty   = empty_q;
  assign bus.count   = count_q;
  assign bus.tx_send = tx_send_q;
  assign bus.tx_data = tx_data_q;

`ifdef UART_TX_FIFO_OVF_EN
  logic ovf_q;
  // sticky overflow: a dropped write sets it and wins over a same-cycle clear
  always_ff @(posedge clk)
    ovf_q <= !rst_n ? 1'b0 : (bus.wr_en && !accept) ? 1'b1 : bus.ovf_clr ? 1'b0 : ovf_q;
  assign bus.ovf = ovf_q;
`endif
endmodule
